// File: rtl/fsm_seq_driver.sv
// rtl/fsm_seq_driver.sv - serial stimulus driver for a sequence detector under test
//
// Purpose: on start, resets the attached detector for one cycle, shifts out up to
// 8 captured pattern bits MSB first, counts the detector's det_y hits, then
// pulses done.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - run request, sampled only in IDLE
//   pattern    - stimulus bits, MSB sent first
//   len        - number of bits to send (values above 8 treated as 8)
//   det_y      - detector output, combinational in det_in
//   det_in     - serial bit to the detector
//   det_rst_n  - active-low reset to the detector
//   busy       - high outside IDLE
//   done       - one-cycle completion pulse
//   hit_count  - det_y=1 samples counted in the last run
//   state_num  - IDLE=0, CLR=1, SHIFT=2, DONE=3
module fsm_seq_driver (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] pattern,
   input  logic [3:0] len,
   input  logic       det_y,
   output logic       det_in,
   output logic       det_rst_n,
   output logic       busy,
   output logic       done,
   output logic [3:0] hit_count,
   output logic [1:0] state_num
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLR   = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0] state;
   logic [2:0] idx;
   logic [7:0] pat_q;
   logic [3:0] len_q;
   // Goes high on the first edge after reset so det_rst_n is held low during
   // reset yet released without needing a state transition.
   logic       alive;
   logic [2:0] bit_sel;
   logic       last_bit;

   assign bit_sel  = 3'd7 - idx;
   assign last_bit = ({1'b0, idx} == (len_q - 4'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= 3'd0;
         pat_q     <= 8'd0;
         len_q     <= 4'd0;
         hit_count <= 4'd0;
         alive     <= 1'b0;
      end else begin
         alive <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pat_q     <= pattern;
                  len_q     <= (len > 4'd8) ? 4'd8 : len;
                  hit_count <= 4'd0;
                  idx       <= 3'd0;
                  state     <= S_CLR;
               end
            end
            S_CLR: begin
               idx   <= 3'd0;
               state <= (len_q != 4'd0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
               if (det_y) begin
                  hit_count <= hit_count + 4'd1;
               end
               idx <= idx + 3'd1;
               if (last_bit) begin
                  state <= S_DONE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign det_in    = (state == S_SHIFT) ? pat_q[bit_sel] : 1'b0;
   assign det_rst_n = alive && (state != S_CLR);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign state_num = state;

endmodule

// File: tb/tb_fsm_seq_driver.sv
// tb/tb_fsm_seq_driver.sv - self-checking bench for fsm_seq_driver
module tb_fsm_seq_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = 8'd0;
   logic [3:0] len = 4'd0;
   logic       det_y;
   logic       det_in;
   logic       det_rst_n;
   logic       busy;
   logic       done;
   logic [3:0] hit_count;
   logic [1:0] state_num;
   logic       echo_mode = 1'b0;

   int checks = 0;
   int errors = 0;

   logic exp_q[$];

   // Detector stub: echo or constant zero
   assign det_y = echo_mode ? det_in : 1'b0;

   fsm_seq_driver dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pattern   (pattern),
      .len       (len),
      .det_y     (det_y),
      .det_in    (det_in),
      .det_rst_n (det_rst_n),
      .busy      (busy),
      .done      (done),
      .hit_count (hit_count),
      .state_num (state_num)
   );

   always #5 clk = ~clk;

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (state_num !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || det_in !== 1'b0 ||
          det_rst_n !== 1'b0 || hit_count !== 4'd0) begin
         errors++;
         $display("FAIL %s: state=%0d busy=%b done=%b det_in=%b det_rst_n=%b hits=%0d, required 0 0 0 0 0 0",
                  tag, state_num, busy, done, det_in, det_rst_n, hit_count);
      end
   endtask

   // One run; the model pushes the expected bits and compares as the DUT shifts.
   task automatic run_one(input logic [7:0] pat, input logic [3:0] ln, input bit echo,
                          input bit hold, input bit disturb);
      int  eff;
      int  exp_hits;
      int  n;
      bit  finished;
      logic b;
      echo_mode = echo;
      pattern   = pat;
      len       = ln;
      eff       = (ln > 4'd8) ? 8 : int'(ln);
      exp_q.delete();
      exp_hits  = 0;
      for (int i = 0; i < eff; i++) begin
         b = pat[7-i];
         exp_q.push_back(b);
         if (echo && b) exp_hits++;
      end
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      n = 0;
      finished = 1'b0;
      while (!finished && n < 40) begin
         @(negedge clk);
         n++;
         if (disturb && n == 3) begin
            start = 1'b1; pattern = ~pat; len = 4'd1;
         end else if (disturb && n == 4) begin
            start = hold;
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy: got %b required 1 at cycle %0d", busy, n);
         end
         if (n == 1) begin
            checks++;
            if (state_num !== 2'd1 || det_rst_n !== 1'b0 || det_in !== 1'b0) begin
               errors++;
               $display("FAIL clr_cycle: state=%0d det_rst_n=%b det_in=%b required 1 0 0",
                        state_num, det_rst_n, det_in);
            end
         end
         if (state_num == 2'd2) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL shift_extra: extra SHIFT cycle %0d, required none", n);
            end else begin
               b = exp_q.pop_front();
               if (det_in !== b || det_rst_n !== 1'b1) begin
                  errors++;
                  $display("FAIL shift_bit: cycle %0d det_in=%b det_rst_n=%b required %b 1",
                           n, det_in, det_rst_n, b);
               end
            end
         end
         if (done === 1'b1) begin
            finished = 1'b1;
            checks++;
            if (n != eff + 2 || state_num !== 2'd3 || det_in !== 1'b0 || det_rst_n !== 1'b1) begin
               errors++;
               $display("FAIL done_latency: cycle %0d state=%0d det_in=%b det_rst_n=%b required cycle %0d state 3 0 1",
                        n, state_num, det_in, det_rst_n, eff + 2);
            end
            checks++;
            if (hit_count !== exp_hits[3:0]) begin
               errors++;
               $display("FAIL hit_count: got %0d required %0d", hit_count, exp_hits);
            end
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL bit_count: %0d bits not driven, required 0", exp_q.size());
            end
         end
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within 40 cycles, required done at %0d", eff + 2);
      end
      @(negedge clk);
      checks++;
      if (state_num !== 2'd0 || done !== 1'b0 || hit_count !== exp_hits[3:0] || det_rst_n !== 1'b1) begin
         errors++;
         $display("FAIL post_done: state=%0d done=%b hits=%0d det_rst_n=%b required 0 0 %0d 1",
                  state_num, done, hit_count, det_rst_n, exp_hits);
      end
   endtask

   task automatic test_reset();
      #2;
      check_reset_outputs("reset_async");
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (det_rst_n !== 1'b0) begin
         errors++;
         $display("FAIL det_rst_n_pre_edge: got %b required 0", det_rst_n);
      end
      @(negedge clk);
      checks++;
      if (det_rst_n !== 1'b1 || state_num !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: det_rst_n=%b state=%0d busy=%b required 1 0 0",
                  det_rst_n, state_num, busy);
      end
   endtask

   task automatic test_echo_full();
      run_one(8'b1011_0010, 4'd8, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_zero_stub();
      run_one(8'hFF, 4'd3, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_len_zero();
      run_one(8'h5A, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_len_clamp();
      run_one(8'hA5, 4'd13, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      run_one(8'b1100_1110, 4'd6, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      int n;
      run_one(8'b0110_1001, 4'd5, 1'b1, 1'b1, 1'b1);
      // start still high: IDLE samples it and the next run begins
      @(negedge clk);
      checks++;
      if (state_num !== 2'd1) begin
         errors++;
         $display("FAIL relaunch: state=%0d required 1", state_num);
      end
      start = 1'b0;
      n = 0;
      while (state_num != 2'd0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (state_num !== 2'd0) begin
         errors++;
         $display("FAIL relaunch_timeout: state=%0d required 0", state_num);
      end
   endtask

   task automatic test_mid_run_reset();
      int n;
      bit saw_done;
      echo_mode = 1'b1;
      pattern   = 8'hFF;
      len       = 4'd8;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // cycle 1 is CLR, cycles 2..5 are SHIFT 1..4
      for (int i = 0; i < 5; i++) @(negedge clk);
      checks++;
      if (state_num !== 2'd2 || hit_count !== 4'd3) begin
         errors++;
         $display("FAIL pre_abort: state=%0d hits=%0d required 2 3", state_num, hit_count);
      end
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("reset_mid_run");
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort_done: done seen during reset, required none");
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (det_rst_n !== 1'b1 || state_num !== 2'd0) begin
         errors++;
         $display("FAIL abort_idle: det_rst_n=%b state=%0d required 1 0", det_rst_n, state_num);
      end
      n = 0;
      run_one(8'b1001_0110, 4'd7, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_echo_full();
      test_zero_stub();
      test_len_zero();
      test_len_clamp();
      test_busy_ignore();
      test_back_to_back();
      test_mid_run_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_seq_driver.md
FSM_SEQ_DRIVER -- requirements
Module: fsm_seq_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a test run; sampled only in IDLE.
REQ-005 Port pattern, input, 8 bits: serial stimulus bits, sent MSB first.
REQ-006 Port len, input, 4 bits: number of pattern bits to send.
REQ-007 Port det_y, input, 1 bit: Mealy output of the driven sequence detector, combinational in det_in.
REQ-008 Port det_in, output, 1 bit: serial bit driven to the detector's in.
REQ-009 Port det_rst_n, output, 1 bit: active-low reset driven to the detector.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.
REQ-011 Port done, output, 1 bit: single-cycle completion pulse.
REQ-012 Port hit_count, output, 4 bits: count of det_y=1 samples in the last run.
REQ-013 Port state_num, output, 2 bits: encoded state, IDLE=0, CLR=1, SHIFT=2, DONE=3.

Function
REQ-014 The block SHALL be a Moore-style controller with states IDLE, CLR, SHIFT and DONE; all outputs except hit_count SHALL be decoded from the registered state and bit index.
REQ-015 IDLE: if start=1 at a rising edge, the block SHALL capture pattern and len, clear hit_count to 0 and go to CLR; otherwise it SHALL stay in IDLE.
REQ-016 Capture SHALL clamp len: len=0 stays 0, and len>8 is stored as 8.
REQ-017 CLR SHALL last exactly one cycle with det_rst_n=0 and det_in=0, then go to SHIFT if the captured len is not 0, else go to DONE.
REQ-018 SHIFT: det_in SHALL equal captured pattern[7-idx], where idx is a 3-bit index starting at 0; det_rst_n SHALL be 1.
REQ-019 At each SHIFT rising edge, hit_count SHALL increment by 1 if det_y=1 (det_y is sampled in the same cycle the bit is driven), and idx SHALL increment.
REQ-020 SHIFT SHALL go to DONE on the edge that samples bit number len-1; exactly len bits SHALL be driven.
REQ-021 DONE SHALL last one cycle with done=1 and det_in=0, then go to IDLE.
REQ-022 hit_count SHALL hold its value after DONE until the next accepted start; the maximum value is 8, so no overflow occurs.
REQ-023 start SHALL be ignored while busy=1; changes to pattern or len while busy SHALL have no effect on the current run.
REQ-024 Latency: for a start sampled at edge E0, done SHALL be high in the cycle after edge E(len+1), that is len+2 cycles after E0 (2 cycles when len=0).
REQ-025 det_rst_n SHALL be 1 in IDLE, SHIFT and DONE.

Reset
REQ-026 While rst=1, asynchronously and regardless of clk: state=IDLE, idx=0, hit_count=0, busy=0, done=0, det_in=0, det_rst_n=0, state_num=0.
REQ-027 After rst falls, det_rst_n SHALL read 1 from the first rising edge onward while the block remains in IDLE.
REQ-028 Assertion of rst in the middle of a run SHALL abort the run with no done pulse; the captured pattern and len SHALL be discarded.

Verification
REQ-029 Echo stub (det_y=det_in), pattern=8'b1011_0010, len=8, start pulse -> det_in sequence 1,0,1,1,0,0,1,0 over 8 SHIFT cycles; done 10 cycles after start edge; hit_count=4.
REQ-030 Stub det_y=0, pattern=8'hFF, len=3 -> exactly 3 SHIFT cycles with det_in=1; done 5 cycles after start; hit_count=0; CLR cycle shows det_rst_n=0.
REQ-031 len=0, start -> state sequence 0,1,3,0; no SHIFT cycle; done after 2 cycles; hit_count=0.
REQ-032 len=4'd13, pattern=8'hA5, echo stub -> 8 bits driven (clamped); hit_count=4.
REQ-033 start held high continuously, and a second start pulse during SHIFT -> the second pulse has no effect; after done, start still high launches a new run on the edge after DONE.
REQ-034 rst asserted in the 4th SHIFT cycle of an 8-bit run -> all outputs take reset values immediately with no done pulse; after release and a new start, a run completes normally.
